// File: rtl/mem_ctrl_if.sv
// Requester/RAM-side bundle for mem_ctrl: fetch port, load/store port,
// byte-wide RAM port and the stall requests to the stall controller.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [31:0] if_data;
  logic        if_done;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        if_rq;
  logic        mem_rq;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output ram_a, ram_wr, ram_dout, if_data, if_done, mem_rdata, mem_done, if_rq, mem_rq
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  ram_a, ram_wr, ram_dout, if_data, if_done, mem_rdata, mem_done, if_rq, mem_rq
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises 32-bit fetches and 1/2/4-byte loads/stores onto a byte-wide RAM,
// one byte per cycle, little-endian; loads take priority over fetches.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_ram_a;
  logic        r_ram_wr;
  logic [7:0]  r_ram_dout;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;
  logic        r_if_done;
  logic        r_mem_done;

  logic [1:0]  w_lane;
  logic [31:0] w_merged;
  logic [31:0] w_next_a;

  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [4:0] sh;
    sh = {lane, 3'b000};
    return (word & ~(32'h0000_00FF << sh)) | ({24'd0, b} << sh);
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  lane);
    logic [31:0] t;
    t = word >> {lane, 3'b000};
    return t[7:0];
  endfunction

  // The byte on ram_din belongs to the address issued one edge earlier (cnt-1).
  assign w_lane   = r_cnt[1:0] - 2'd1;
  assign w_merged = merge_lane(r_buf, w_lane, bus.ram_din);
  assign w_next_a = r_base + {29'd0, r_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_ram_a     <= 32'd0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'd0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ram_a  <= 32'd0;
          r_ram_wr <= 1'b0;
          // A done cycle is a dead cycle so a still-held request is not re-taken.
          if (!r_if_done && !r_mem_done) begin
            if (bus.mem_req) begin
              r_ram_a <= bus.mem_addr;
              r_base  <= bus.mem_addr;
              r_cnt   <= 3'd1;
              r_n     <= byte_count(bus.mem_len);
              r_wdata <= bus.mem_wdata;
              r_buf   <= 32'd0;
              if (bus.mem_we) begin
                r_ram_wr   <= 1'b1;
                r_ram_dout <= bus.mem_wdata[7:0];
                r_state    <= MEM_WR;
              end else begin
                r_state    <= MEM_RD;
              end
            end else if (bus.if_req) begin
              r_ram_a <= bus.if_addr;
              r_base  <= bus.if_addr;
              r_cnt   <= 3'd1;
              r_n     <= 3'd4;
              r_buf   <= 32'd0;
              r_state <= IF_RD;
            end
          end
        end
        IF_RD, MEM_RD: begin
          r_cnt <= r_cnt + 3'd1;
          r_buf <= w_merged;
          if (r_cnt < r_n) r_ram_a <= w_next_a;
          if (r_cnt == r_n) begin
            r_ram_a <= 32'd0;
            r_state <= IDLE;
            if (r_state == IF_RD) begin
              r_if_data <= w_merged;
              r_if_done <= 1'b1;
            end else begin
              r_mem_rdata <= w_merged;
              r_mem_done  <= 1'b1;
            end
          end
        end
        MEM_WR: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < r_n) begin
            r_ram_a    <= w_next_a;
            r_ram_dout <= byte_sel(r_wdata, r_cnt[1:0]);
          end else begin
            r_ram_a    <= 32'd0;
            r_ram_wr   <= 1'b0;
            r_state    <= IDLE;
            r_mem_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ram_a     = r_ram_a;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.if_data   = r_if_data;
  assign bus.if_done   = r_if_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_done  = r_mem_done;
  assign bus.if_rq     = bus.if_req & ~r_if_done;
  assign bus.mem_rq    = bus.mem_req & ~r_mem_done;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have these ports, each listed as name, direction, width and meaning:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset, synchronous, active-high.
- if_req, in, 1, fetch request, held until if_done.
- if_addr, in, 32, fetch byte address.
- mem_req, in, 1, load/store request, held until mem_done.
- mem_we, in, 1, 1 = store, 0 = load.
- mem_addr, in, 32, load/store byte address.
- mem_len, in, 2, access width: 00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- mem_wdata, in, 32, store data, little-endian, low bytes used.
- ram_din, in, 8, RAM read byte.
- ram_a, out, 32, RAM byte address.
- ram_wr, out, 1, RAM write strobe.
- ram_dout, out, 8, RAM write byte.
- if_data, out, 32, fetched word.
- if_done, out, 1, one-cycle completion pulse for a fetch.
- mem_rdata, out, 32, load data, zero-extended.
- mem_done, out, 1, one-cycle completion pulse for a load or store.
- if_rq, out, 1, fetch stall request to the stall controller.
- mem_rq, out, 1, memory stall request to the stall controller.

Function
REQ-002 The block SHALL implement the states IDLE, IF_RD, MEM_RD and MEM_WR, plus a 3-bit byte counter cnt.
REQ-003 RAM timing: a read byte SHALL appear on ram_din in the cycle after its address is driven on ram_a; a write SHALL be taken by the RAM at the edge ending the cycle in which ram_wr=1.
REQ-004 The block SHALL register ram_a, ram_wr and ram_dout.
REQ-005 In IDLE the block SHALL drive ram_a=0 and ram_wr=0.
REQ-006 Accept edge: in IDLE with if_done=0 and mem_done=0, a high mem_req SHALL be accepted before a high if_req.
- On acceptance: ram_a <= address, cnt <= 1, and the state SHALL move to MEM_RD, MEM_WR or IF_RD.
- For a store: ram_wr <= 1 and ram_dout <= mem_wdata[7:0].
REQ-007 In the cycle a done output is high, the block SHALL NOT accept a new request, even if the request is still high.
REQ-008 Byte count N SHALL be 1, 2 or 4 per mem_len. A fetch SHALL always use N = 4.
REQ-009 Read states: on each edge with cnt < N, the block SHALL drive ram_a <= base + cnt. On each edge with cnt >= 1, it SHALL capture ram_din into byte lane cnt-1. cnt SHALL increment every edge.
REQ-010 Read completion: on the edge that captures byte N-1, the block SHALL return to IDLE and pulse the matching done output for one cycle.
REQ-011 MEM_WR: on each edge with cnt < N, the block SHALL drive ram_a <= base + cnt and ram_dout <= mem_wdata byte cnt, with ram_wr held at 1.
REQ-012 Write completion: on the edge with cnt = N, the block SHALL set ram_wr <= 0, return to IDLE and pulse mem_done.
REQ-013 Latency from the accept edge to done high SHALL be exactly N+1 cycles for reads and for writes.
REQ-014 Lane ordering SHALL be little-endian, with byte i placed in bits [8i+7:8i].
REQ-015 mem_rdata bits above 8N SHALL be 0. Sign extension is not performed by this block.
REQ-016 if_data and mem_rdata SHALL hold their last value until overwritten by the next transaction of the same type.
REQ-017 Address arithmetic SHALL be 32-bit modulo, so 0xFFFFFFFF + 1 wraps to 0x00000000.
REQ-018 Stall outputs SHALL be combinational: if_rq = if_req & ~if_done, and mem_rq = mem_req & ~mem_done.
REQ-019 A fetch request arriving during a memory transaction SHALL wait, with if_rq high, until the memory transaction completes and IDLE is re-entered.
REQ-020 Base address, mem_len, mem_we and mem_wdata SHALL be latched at the accept edge, so input changes mid-transaction have no effect.
REQ-021 A request that drops before completion SHALL NOT abort the transaction. The transaction completes and done still pulses.

Reset
REQ-022 With rst=1 at an edge, the block SHALL enter IDLE and clear cnt. It SHALL set ram_a, ram_wr, ram_dout, if_data, mem_rdata, if_done and mem_done to 0.
REQ-023 Reset mid-transaction SHALL abandon the access with no done pulse. For a store, ram_wr SHALL be 0 from the next cycle.
REQ-024 rst SHALL NOT gate if_rq or mem_rq, which follow the requests combinationally.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Fetch: RAM[0x100..0x103] = 13,05,00,00 and if_req at 0x100 -> ram_a = 0x100..0x103 on consecutive cycles; if_done high 5 cycles after the accept edge; if_data = 0x00000513.
- Store word: 0xDEADBEEF to 0x200 -> writes EF,BE,AD,DE to 0x200..0x203; ram_wr high for 4 cycles; mem_done pulse on the 5th cycle.
- Halfword load: RAM[0x201] = 0xBE and mem_len = 01 at 0x200 -> mem_rdata = 0x0000BEEF; done 3 cycles after accept.
- Simultaneous requests: if_req and mem_req both high in IDLE -> memory access first with if_rq high throughout; fetch accepted on the edge after mem_done drops; no access accepted during either done cycle.
- Reset mid-store: rst asserted on the 2nd write byte -> ram_wr = 0 next cycle; state IDLE; no mem_done pulse; all outputs 0.
- Wrap: 4-byte load at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
